// File: rtl/avalon_st_if.sv
// Avalon-ST beat bundle shared by the classifier sink and source ports.
// Byte 0 of a beat sits in data[DWIDTH-1 -: 8]; empty counts unused bytes on eop.
interface avalon_st_if #(
    parameter int DWIDTH        = 64,
    parameter int CHANNEL_WIDTH = 1
);
    localparam int EMPTY_WIDTH = $clog2(DWIDTH / 8);

    logic [DWIDTH-1:0]        data;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic                     valid;
    logic                     ready;
    logic                     sop;
    logic                     eop;
    logic [CHANNEL_WIDTH-1:0] channel;

    modport sink (
        input  data, empty, valid, sop, eop, channel,
        output ready
    );

    modport src (
        output data, empty, valid, sop, eop, channel,
        input  ready
    );
endinterface

// File: rtl/packet_classifier.sv
// Ethernet DA/EtherType classifier: forwards beats with one register stage and marks pass/drop on channel.
// Optional pass/drop counters are built when PACKET_CLASSIFIER_STATS_EN is defined.
module packet_classifier #(
    parameter int AST_DWIDTH    = 64,
    parameter int CHANNEL_WIDTH = 1
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    avalon_st_if.sink   sink_if,
    avalon_st_if.src    src_if,
    input  logic [47:0] dst_mac_i,
    input  logic        bcast_en_i,
    input  logic [15:0] ethertype_i,
    input  logic        ethertype_chk_i
`ifdef PACKET_CLASSIFIER_STATS_EN
    ,
    output logic [15:0] pass_cnt_o,
    output logic [15:0] drop_cnt_o
`endif
);

    // state   | meaning
    // IDLE_S  | waiting for sop; non-sop beats are swallowed
    // HDR_S   | word0 seen, DA compare registered, awaiting word1
    // BODY_S  | verdict fixed, forwarding the remaining body
    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        HDR_S  = 2'd1,
        BODY_S = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [AST_DWIDTH-1:0]    r_data;
    logic [2:0]               r_empty;
    logic                     r_valid;
    logic                     r_sop;
    logic                     r_eop;
    logic [CHANNEL_WIDTH-1:0] r_channel;

    logic        r_da_hit;
    logic        r_verdict;
    logic [15:0] r_ethertype;
    logic        r_eth_chk;

    logic        w_xfer;
    logic        w_fwd;
    logic        w_ch_bit;
    logic        w_load_verdict;
    logic [47:0] w_da;
    logic        w_da_hit;
    logic        w_verdict_calc;
    logic        w_unused_chan;

    assign w_unused_chan = ^sink_if.channel;

    assign sink_if.ready = ~r_valid | src_if.ready;
    assign w_xfer        = sink_if.valid & sink_if.ready;

    assign w_da           = sink_if.data[AST_DWIDTH-1 -: 48];
    assign w_da_hit       = (w_da == dst_mac_i) | (bcast_en_i & (&w_da));
    assign w_verdict_calc = r_da_hit & (~r_eth_chk | (sink_if.data[31:16] == r_ethertype));

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= IDLE_S;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fwd          = 1'b0;
        w_ch_bit       = 1'b0;
        w_load_verdict = 1'b0;
        if (w_xfer) begin
            if (sink_if.sop) begin
                // Any sop restarts classification; a single-beat packet is a runt.
                w_fwd       = 1'b1;
                w_state_nxt = sink_if.eop ? IDLE_S : HDR_S;
            end else begin
                case (r_state)
                    HDR_S: begin
                        w_fwd = 1'b1;
                        if (sink_if.eop) begin
                            w_state_nxt = IDLE_S;
                        end else begin
                            w_ch_bit       = w_verdict_calc;
                            w_load_verdict = 1'b1;
                            w_state_nxt    = BODY_S;
                        end
                    end
                    BODY_S: begin
                        w_fwd    = 1'b1;
                        w_ch_bit = r_verdict;
                        if (sink_if.eop) begin
                            w_state_nxt = IDLE_S;
                        end
                    end
                    default: begin
                        w_state_nxt = IDLE_S;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_da_hit    <= 1'b0;
            r_verdict   <= 1'b0;
            r_ethertype <= 16'd0;
            r_eth_chk   <= 1'b0;
        end else if (w_xfer) begin
            if (sink_if.sop) begin
                r_da_hit    <= w_da_hit;
                r_verdict   <= 1'b0;
                r_ethertype <= ethertype_i;
                r_eth_chk   <= ethertype_chk_i;
            end else if (w_load_verdict) begin
                r_verdict <= w_verdict_calc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_empty   <= '0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_channel <= '0;
        end else if (w_xfer && w_fwd) begin
            r_valid   <= 1'b1;
            r_data    <= sink_if.data;
            r_empty   <= sink_if.empty;
            r_sop     <= sink_if.sop;
            r_eop     <= sink_if.eop;
            r_channel <= CHANNEL_WIDTH'(w_ch_bit);
        end else if (src_if.ready) begin
            r_valid <= 1'b0;
        end
    end

    assign src_if.valid   = r_valid;
    assign src_if.data    = r_data;
    assign src_if.empty   = r_empty;
    assign src_if.sop     = r_sop;
    assign src_if.eop     = r_eop;
    assign src_if.channel = r_channel;

`ifdef PACKET_CLASSIFIER_STATS_EN
    logic [15:0] r_pass_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_pass_cnt <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else if (w_xfer && w_fwd && sink_if.eop) begin
            if (w_ch_bit) begin
                if (r_pass_cnt != 16'hFFFF) r_pass_cnt <= r_pass_cnt + 16'd1;
            end else begin
                if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign pass_cnt_o = r_pass_cnt;
    assign drop_cnt_o = r_drop_cnt;
`endif

endmodule

// File: tb/tb_packet_classifier.sv
// Randomized bench for packet_classifier against a packet-level reference model.
// Counter checks are compiled in when PACKET_CLASSIFIER_STATS_EN is defined.
module tb_packet_classifier;

    logic clk_sys = 1'b0;
    logic arstn   = 1'b0;
    always #5 clk_sys = ~clk_sys;

    avalon_st_if #(.DWIDTH(64), .CHANNEL_WIDTH(1)) sink_if ();
    avalon_st_if #(.DWIDTH(64), .CHANNEL_WIDTH(1)) src_if ();

    logic [47:0] dst_mac;
    logic        bcast_en;
    logic [15:0] etype;
    logic        etype_chk;
`ifdef PACKET_CLASSIFIER_STATS_EN
    logic [15:0] pass_cnt;
    logic [15:0] drop_cnt;
`endif

    packet_classifier #(.AST_DWIDTH(64), .CHANNEL_WIDTH(1)) u_dut (
        .clk_i           (clk_sys),
        .arstn_i         (arstn),
        .sink_if         (sink_if),
        .src_if          (src_if),
        .dst_mac_i       (dst_mac),
        .bcast_en_i      (bcast_en),
        .ethertype_i     (etype),
        .ethertype_chk_i (etype_chk)
`ifdef PACKET_CLASSIFIER_STATS_EN
        ,
        .pass_cnt_o      (pass_cnt),
        .drop_cnt_o      (drop_cnt)
`endif
    );

    typedef struct {
        logic [63:0] d;
        logic [2:0]  e;
        logic        s;
        logic        eo;
        logic        ch;
    } beat_t;

    beat_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    m_pass  = 0;
    int    m_drop  = 0;
    bit    rdy_rand = 1'b0;
    bit    stall_prev = 1'b0;
    logic [63:0] stall_data;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk_sys) begin
        #1;
        src_if.ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk_sys) begin
        if (!arstn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(src_if.valid), 64'd1);
                chk("hold_data", src_if.data, stall_data);
            end
            if (src_if.valid && src_if.ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    chk("out_data", src_if.data, b.d);
                    chk("out_ctl", {59'd0, src_if.sop, src_if.eop, src_if.empty},
                        {59'd0, b.s, b.eo, b.e});
                    chk(b.eo ? "eop_channel" : "channel", 64'(src_if.channel), 64'(b.ch));
                end
            end
            stall_prev = src_if.valid && !src_if.ready;
            stall_data = src_if.data;
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic send_beat(input logic [63:0] d, input logic s, input logic eo,
                             input logic [2:0] e, input logic fwd, input logic ch,
                             input logic lat);
        int   to;
        logic acc;
        to = 0;
        sink_if.data  = d;
        sink_if.sop   = s;
        sink_if.eop   = eo;
        sink_if.empty = e;
        sink_if.valid = 1'b1;
        do begin
            @(negedge clk_sys);
            acc = sink_if.ready;
            @(posedge clk_sys);
            to++;
        end while (!acc && to < 1000);
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        if (fwd) begin
            exp_q.push_back('{d: d, e: e, s: s, eo: eo, ch: ch});
            if (eo) begin
                if (ch) m_pass++;
                else    m_drop++;
            end
        end
        #1;
        sink_if.valid = 1'b0;
        if (lat) begin
            chk("lat_valid", 64'(src_if.valid), 64'd1);
            chk("lat_data", src_if.data, d);
        end
    endtask

    task automatic randomize_cfg();
        dst_mac   = {16'($urandom), $urandom};
        bcast_en  = 1'($urandom_range(0, 1));
        etype     = 16'($urandom);
        etype_chk = 1'($urandom_range(0, 1));
    endtask

    // Expected channel: 0 on word0 and on runts, otherwise the packet verdict.
    task automatic run_pkt(input int n, input int n_send, input logic [47:0] da,
                           input logic [15:0] et, input bit scramble, input bit lat,
                           input int gap_max);
        logic        hit;
        logic        v;
        logic [63:0] d;
        logic [2:0]  e;
        logic        ch;
        hit = (da == dst_mac) || (bcast_en && da == 48'hFFFF_FFFF_FFFF);
        v   = hit && (!etype_chk || et == etype);
        for (int i = 0; i < n_send; i++) begin
            d = {$urandom, $urandom};
            if (i == 0) d[63:16] = da;
            if (i == 1) d[31:16] = et;
            ch = (i == 0 || n <= 2) ? 1'b0 : v;
            e  = (i == n - 1) ? 3'($urandom_range(0, 7)) : 3'd0;
            send_beat(d, i == 0, i == n - 1, e, 1'b1, ch, lat);
            if (i == 0 && scramble) randomize_cfg();
            if (gap_max > 0) tick($urandom_range(0, gap_max));
        end
    endtask

    task automatic drain();
        int to;
        to = 0;
        while ((exp_q.size() != 0 || src_if.valid) && to < 500) begin
            tick(1);
            to++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_counters();
`ifdef PACKET_CLASSIFIER_STATS_EN
        chk("pass_cnt", 64'(pass_cnt), 64'(m_pass));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
    endtask

    initial begin
        logic [47:0] mac;
        logic [47:0] da;
        logic [15:0] et;
        int          sel;
        mac               = 48'h0011_2233_4455;
        dst_mac           = mac;
        bcast_en          = 1'b0;
        etype             = 16'h0800;
        etype_chk         = 1'b0;
        sink_if.valid     = 1'b0;
        sink_if.data      = '0;
        sink_if.sop       = 1'b0;
        sink_if.eop       = 1'b0;
        sink_if.empty     = '0;
        sink_if.channel   = '0;

        tick(3);
        chk("rst_valid", 64'(src_if.valid), 64'd0);
        chk("rst_sop", 64'(src_if.sop), 64'd0);
        chk("rst_eop", 64'(src_if.eop), 64'd0);
        chk("rst_channel", 64'(src_if.channel), 64'd0);
        chk("rst_data", src_if.data, 64'd0);
        chk("rst_empty", 64'(src_if.empty), 64'd0);
        chk_counters();
        @(negedge clk_sys);
        arstn = 1'b1;
        tick(1);
        chk("rdy_after_rst", 64'(sink_if.ready), 64'd1);

        // Unicast hit, EtherType check off: channel 0 then 1s, one cycle latency.
        run_pkt(8, 8, mac, 16'h1234, 1'b0, 1'b1, 0);
        drain();
        chk_counters();

        // Broadcast DA, without then with broadcast enable.
        run_pkt(8, 8, 48'hFFFF_FFFF_FFFF, 16'h0800, 1'b0, 1'b1, 0);
        drain();
        chk_counters();
        bcast_en = 1'b1;
        run_pkt(8, 8, 48'hFFFF_FFFF_FFFF, 16'h0800, 1'b0, 1'b1, 0);
        drain();

        // EtherType mismatch with the check enabled.
        bcast_en  = 1'b0;
        etype_chk = 1'b1;
        run_pkt(8, 8, mac, 16'h86DD, 1'b0, 1'b1, 0);
        drain();
        run_pkt(4, 4, mac, 16'h0800, 1'b0, 1'b1, 0);
        drain();
        chk_counters();

        // Runt, stray non-sop beat, then a normal packet.
        etype_chk = 1'b0;
        run_pkt(2, 2, mac, 16'h0800, 1'b0, 1'b1, 0);
        send_beat({$urandom, $urandom}, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        run_pkt(5, 5, mac, 16'h0800, 1'b0, 1'b1, 0);
        drain();
        chk_counters();

        // Reset in the middle of an 8-beat packet.
        run_pkt(8, 4, mac, 16'h0800, 1'b0, 1'b0, 0);
        @(posedge clk_sys);
        #3;
        arstn = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(src_if.valid), 64'd0);
        exp_q.delete();
        m_pass = 0;
        m_drop = 0;
        chk_counters();
        @(negedge clk_sys);
        arstn = 1'b1;
        tick(1);
        chk("rdy_after_mid_rst", 64'(sink_if.ready), 64'd1);
        run_pkt(8, 8, mac, 16'h0800, 1'b0, 1'b1, 0);
        drain();
        chk_counters();

        // Random back-to-back traffic with random downstream backpressure.
        rdy_rand = 1'b1;
        for (int p = 0; p < 100; p++) begin
            sel = $urandom_range(0, 2);
            da  = (sel == 0) ? dst_mac : (sel == 1) ? 48'hFFFF_FFFF_FFFF : {16'($urandom), $urandom};
            et  = ($urandom_range(0, 1) == 1) ? etype : 16'($urandom);
            run_pkt($urandom_range(1, 10), 0, da, et, 1'b0, 1'b0, 0);
            begin
                int n;
                n = $urandom_range(1, 10);
                run_pkt(n, n, da, et, ($urandom_range(0, 3) == 0), 1'b0,
                        ($urandom_range(0, 3) == 0) ? 2 : 0);
            end
            if ($urandom_range(0, 9) == 0)
                send_beat({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), 3'd0,
                          1'b0, 1'b0, 1'b0);
        end
        rdy_rand = 1'b0;
        tick(2);
        drain();
        chk_counters();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_classifier.md
PACKET_CLASSIFIER -- requirements
Module: packet_classifier

Interface
REQ-001 SHALL have parameter AST_DWIDTH, default 64, Avalon-ST data width in bits; only 64 is supported.
REQ-002 SHALL have parameter CHANNEL_WIDTH, default 1, width of the output channel field.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk_i (input, 1), posedge clock; arstn_i (input, 1), reset asserted when low.
REQ-004 SHALL have sink_if (avalon_st_if.sink, AST_DWIDTH data): packet input; its channel input is ignored.
REQ-005 SHALL have src_if (avalon_st_if.src, AST_DWIDTH data): packet output to the packet_resolver stage.
REQ-006 SHALL have dst_mac_i (input, 48): unicast destination MAC to accept.
REQ-007 SHALL have bcast_en_i (input, 1): also accept destination FF:FF:FF:FF:FF:FF.
REQ-008 SHALL have ethertype_i (input, 16) and ethertype_chk_i (input, 1): required EtherType, and its enable.

Function
REQ-009 SHALL order bytes big-endian: byte 0 is data[63:56], DA is word0[63:16], and EtherType is word1[31:16].
REQ-010 SHALL forward every accepted beat through one output register with 1-cycle latency; data, empty, sop and eop SHALL be unchanged.
REQ-011 SHALL drive sink_if.ready = ~src_if.valid | src_if.ready; a beat transfers when valid and ready are both high.
REQ-012 SHALL hold the output beat stable while src_if.valid=1 and src_if.ready=0.
REQ-013 SHALL implement an FSM, advancing only on accepted beats:
- IDLE_S: wait for sop.
- HDR_S: word0 seen, awaiting word1.
- BODY_S: verdict fixed, forwarding the body.
REQ-014 IDLE_S: sop without eop -> HDR_S; sop with eop -> stay in IDLE_S (runt); a beat without sop SHALL be discarded (accepted, not forwarded).
REQ-015 HDR_S: a non-eop beat -> BODY_S; an eop beat -> IDLE_S (runt).
REQ-016 BODY_S: an eop beat -> IDLE_S.
REQ-017 A sop in HDR_S or BODY_S SHALL restart classification as a new word0 (-> HDR_S) and be forwarded unchanged.
REQ-018 SHALL latch dst_mac_i, bcast_en_i, ethertype_i and ethertype_chk_i on sop acceptance and use the latched values for that packet.
REQ-019 On word0, SHALL register da_hit = (DA==dst_mac) | (bcast_en & DA==all-ones).
REQ-020 On word1, SHALL compute verdict = da_hit & (~ethertype_chk | EtherType==ethertype).
REQ-021 SHALL drive src_if.channel = 0 on output word0, and = verdict zero-extended to CHANNEL_WIDTH on word1 and all later beats of the packet.
REQ-022 A runt packet (eop on word0 or word1) SHALL carry channel=0 on its eop beat.
REQ-023 channel on the eop beat is the authoritative pass(1)/drop(0) decision for the downstream stage.

Reset
REQ-024 Asserting arstn_i low SHALL immediately clear: src_if.valid=0, sop=0, eop=0, channel=0, state=IDLE_S, verdict=0, and the counters if present.
REQ-025 src_if.data and src_if.empty SHALL reset to 0.
REQ-026 Reset mid-packet SHALL drop the partial packet; after release the block SHALL wait for the next sop.
REQ-027 sink_if.ready SHALL be 1 one cycle after reset release.

Configuration
REQ-028 With macro PACKET_CLASSIFIER_STATS_EN defined, the block SHALL add outputs pass_cnt_o (16) and drop_cnt_o (16).
REQ-029 These counters SHALL increment on each accepted input eop beat whose channel decision is 1 or 0 respectively, saturate at 0xFFFF, and reset to 0.
REQ-030 Without PACKET_CLASSIFIER_STATS_EN, these ports and counters SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-031 8-beat packet with DA=dst_mac_i=00:11:22:33:44:55, ethertype_chk_i=0, src_if.ready=1 -> 8 output beats, each 1 cycle after input; channel 0,1,1,1,1,1,1,1; pass_cnt_o=1.
REQ-032 Same packet with DA=FF:FF:FF:FF:FF:FF: bcast_en_i=0 -> eop channel=0 and drop_cnt_o=1; bcast_en_i=1 -> eop channel=1.
REQ-033 DA match, ethertype_chk_i=1, ethertype_i=0x0800, packet EtherType 0x86DD -> eop channel=0.
REQ-034 Random src_if.ready (50%) over 100 back-to-back packets -> output beats in order and unaltered, with no loss or duplication.
REQ-035 2-beat runt packet, then a beat without sop, then a valid packet -> runt forwarded with eop channel=0, stray beat absent from the output, third packet classified normally.
REQ-036 arstn_i pulsed low during beat 4 of 8 -> src_if.valid=0 at once; the next full packet is forwarded and classified correctly.
